// File: rtl/rv32i_multicycle_core.sv
// rv32i_multicycle_core
// Multi-cycle RV32I core: FETCH -> DECODE -> EXEC -> {MEM ->} WB, with a sticky
// TRAP state for illegal instructions, misaligned data accesses, misaligned
// control-flow targets and bus timeouts.
// Ports:
//   clk, rst (async active-low)
//   ibus_req/ibus_addr/ibus_ack/ibus_rdata        instruction fetch bus
//   dbus_req/we/addr/be/wdata/ack/rdata           byte-lane data bus
//   retire, halted, trap_cause                    status
//   pc, instr, reg_write, reg_waddr, reg_wdata    debug view of commit
module rv32i_multicycle_core #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        reg_write,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_r;
    logic [31:0]          rf_r [0:31];
    logic [31:0]          rs1_r, rs2_r, imm_r, next_pc_r;
    logic [1:0]           ea_lo_r;
    logic [TIMEOUT_W-1:0] tmo_cnt_r;

    logic [6:0]  opcode_s, f7_s;
    logic [2:0]  f3_s;
    logic [4:0]  rd_s, rs1_idx_s, rs2_idx_s;
    logic [31:0] i_imm_s, imm_s, rs1_val_s, rs2_val_s;
    logic        illegal_s, timeout_s;
    logic [31:0] alu_b_s, alu_res_s, ea_s, next_pc_s, wb_val_s, st_wdata_s;
    logic        alu_alt_s, jump_s, mem_s, misalign_s, writes_rd_s;
    logic [3:0]  be_s;

    function automatic logic [31:0] alu_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f3, input logic alt);
        logic [31:0] r;
        case (f3)
            3'd0:    r = alt ? (a - b) : (a + b);
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'd0, $signed(a) < $signed(b)};
            3'd3:    r = {31'd0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6:    r = a | b;
            3'd7:    r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic br_taken(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
        logic t;
        case (f3)
            3'd0:    t = (a == b);
            3'd1:    t = (a != b);
            3'd4:    t = ($signed(a) < $signed(b));
            3'd5:    t = ($signed(a) >= $signed(b));
            3'd6:    t = (a < b);
            3'd7:    t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Selected byte/halfword lane moved to bit 0, then sign or zero extended.
    function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [1:0] lo,
                                             input logic [2:0] f3);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {lo, 3'b000};
        case (f3)
            3'd0:    r = {{24{sh[7]}}, sh[7:0]};
            3'd1:    r = {{16{sh[15]}}, sh[15:0]};
            3'd4:    r = {24'd0, sh[7:0]};
            3'd5:    r = {16'd0, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    assign opcode_s  = instr[6:0];
    assign rd_s      = instr[11:7];
    assign f3_s      = instr[14:12];
    assign rs1_idx_s = instr[19:15];
    assign rs2_idx_s = instr[24:20];
    assign f7_s      = instr[31:25];
    assign i_imm_s   = {{20{instr[31]}}, instr[31:20]};
    assign rs1_val_s = (rs1_idx_s == 5'd0) ? 32'd0 : rf_r[rs1_idx_s];
    assign rs2_val_s = (rs2_idx_s == 5'd0) ? 32'd0 : rf_r[rs2_idx_s];
    assign ibus_addr = pc;
    assign timeout_s = TMO_EN && (tmo_cnt_r == TMO_LAST);

    // Decode: legality check and immediate generation.
    always_comb begin
        illegal_s = 1'b0;
        imm_s     = 32'd0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC: imm_s = {instr[31:12], 12'd0};
            OPC_JAL:    imm_s = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            OPC_JALR:   begin imm_s = i_imm_s; illegal_s = (f3_s != 3'd0); end
            OPC_BRANCH: begin
                imm_s     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                illegal_s = (f3_s == 3'd2) || (f3_s == 3'd3);
            end
            OPC_LOAD:   begin imm_s = i_imm_s; illegal_s = (f3_s == 3'd3) || (f3_s[2:1] == 2'b11); end
            OPC_STORE:  begin
                imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                illegal_s = f3_s[2] || (f3_s == 3'd3);
            end
            OPC_OPIMM:  begin
                imm_s = i_imm_s;
                if (f3_s == 3'd1) begin
                    illegal_s = (f7_s != 7'd0);
                end else if (f3_s == 3'd5) begin
                    illegal_s = (f7_s != 7'd0) && (f7_s != F7_ALT);
                end else begin
                    illegal_s = 1'b0;
                end
            end
            OPC_OP:     illegal_s = !((f7_s == 7'd0) ||
                                      ((f7_s == F7_ALT) && ((f3_s == 3'd0) || (f3_s == 3'd5))));
            default:    illegal_s = 1'b1;
        endcase
    end

    // Execute: ALU, effective address, next PC, writeback value and store lanes.
    always_comb begin
        alu_b_s     = (opcode_s == OPC_OP) ? rs2_r : imm_r;
        alu_alt_s   = (opcode_s == OPC_OP) ? instr[30] : ((f3_s == 3'd5) && instr[30]);
        alu_res_s   = alu_op(rs1_r, alu_b_s, f3_s, alu_alt_s);
        ea_s        = rs1_r + imm_r;
        next_pc_s   = pc + 32'd4;
        jump_s      = 1'b0;
        wb_val_s    = alu_res_s;
        mem_s       = (opcode_s == OPC_LOAD) || (opcode_s == OPC_STORE);
        writes_rd_s = (opcode_s != OPC_BRANCH) && (opcode_s != OPC_STORE);
        case (opcode_s)
            OPC_LUI:   wb_val_s = imm_r;
            OPC_AUIPC: wb_val_s = pc + imm_r;
            OPC_JAL:   begin wb_val_s = pc + 32'd4; next_pc_s = pc + imm_r; jump_s = 1'b1; end
            OPC_JALR:  begin wb_val_s = pc + 32'd4; next_pc_s = {ea_s[31:1], 1'b0}; jump_s = 1'b1; end
            OPC_BRANCH: begin
                if (br_taken(rs1_r, rs2_r, f3_s)) begin
                    next_pc_s = pc + imm_r;
                    jump_s    = 1'b1;
                end else begin
                    jump_s    = 1'b0;
                end
            end
            default:   jump_s = 1'b0;
        endcase
        case (f3_s[1:0])
            2'd0:    begin misalign_s = 1'b0;             be_s = 4'b0001 << ea_s[1:0];
                           st_wdata_s = {4{rs2_r[7:0]}}; end
            2'd1:    begin misalign_s = ea_s[0];          be_s = ea_s[1] ? 4'b1100 : 4'b0011;
                           st_wdata_s = {2{rs2_r[15:0]}}; end
            default: begin misalign_s = (ea_s[1:0] != 2'd0); be_s = 4'b1111;
                           st_wdata_s = rs2_r; end
        endcase
    end

    // Register file write at the end of the WB cycle; contents are not reset.
    always_ff @(posedge clk) begin
        if ((state_r == S_WB) && reg_write) begin
            rf_r[reg_waddr] <= reg_wdata;
        end
    end

    // Main sequencer with registered bus, status and debug outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_FETCH;
            pc         <= RESET_VECTOR;
            instr      <= 32'd0;
            ibus_req   <= 1'b0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'd0;
            dbus_be    <= 4'd0;
            dbus_wdata <= 32'd0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            trap_cause <= 2'd0;
            reg_write  <= 1'b0;
            reg_waddr  <= 5'd0;
            reg_wdata  <= 32'd0;
            rs1_r      <= 32'd0;
            rs2_r      <= 32'd0;
            imm_r      <= 32'd0;
            next_pc_r  <= 32'd0;
            ea_lo_r    <= 2'd0;
            tmo_cnt_r  <= '0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (!ibus_req) begin
                        ibus_req  <= 1'b1;   // idle cycle after reset
                        tmo_cnt_r <= '0;
                    end else if (ibus_ack) begin
                        ibus_req <= 1'b0;
                        instr    <= ibus_rdata;
                        state_r  <= S_DECODE;
                    end else if (timeout_s) begin
                        ibus_req   <= 1'b0;
                        halted     <= 1'b1;
                        trap_cause <= 2'd3;
                        state_r    <= S_TRAP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
                S_DECODE: begin
                    rs1_r <= rs1_val_s;
                    rs2_r <= rs2_val_s;
                    imm_r <= imm_s;
                    if (illegal_s) begin
                        halted     <= 1'b1;
                        trap_cause <= 2'd0;
                        state_r    <= S_TRAP;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    next_pc_r <= next_pc_s;
                    if (mem_s && misalign_s) begin
                        halted     <= 1'b1;
                        trap_cause <= 2'd1;
                        state_r    <= S_TRAP;
                    end else if (jump_s && next_pc_s[1]) begin
                        halted     <= 1'b1;
                        trap_cause <= 2'd2;
                        state_r    <= S_TRAP;
                    end else if (mem_s) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= (opcode_s == OPC_STORE);
                        dbus_addr  <= {ea_s[31:2], 2'b00};
                        dbus_be    <= be_s;
                        dbus_wdata <= st_wdata_s;
                        ea_lo_r    <= ea_s[1:0];
                        tmo_cnt_r  <= '0;
                        state_r    <= S_MEM;
                    end else begin
                        retire    <= 1'b1;
                        reg_write <= writes_rd_s && (rd_s != 5'd0);
                        reg_waddr <= rd_s;
                        reg_wdata <= wb_val_s;
                        state_r   <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dbus_ack) begin
                        dbus_req  <= 1'b0;
                        dbus_we   <= 1'b0;
                        retire    <= 1'b1;
                        reg_write <= !dbus_we && (rd_s != 5'd0);
                        reg_waddr <= rd_s;
                        reg_wdata <= dbus_we ? 32'd0 : load_ext(dbus_rdata, ea_lo_r, f3_s);
                        state_r   <= S_WB;
                    end else if (timeout_s) begin
                        dbus_req   <= 1'b0;
                        dbus_we    <= 1'b0;
                        halted     <= 1'b1;
                        trap_cause <= 2'd3;
                        state_r    <= S_TRAP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
                S_WB: begin
                    retire    <= 1'b0;
                    reg_write <= 1'b0;
                    pc        <= next_pc_r;
                    ibus_req  <= 1'b1;
                    tmo_cnt_r <= '0;
                    state_r   <= S_FETCH;
                end
                S_TRAP: begin
                    halted <= 1'b1;
                end
                default: begin
                    halted     <= 1'b1;
                    trap_cause <= 2'd0;
                    state_r    <= S_TRAP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Scoreboard bench for rv32i_multicycle_core: directed programs push expected
// commits and data-bus transactions into queues; a monitor pops and compares
// them whenever the core retires or starts a data request.
module tb_rv32i_multicycle_core;
    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } ret_t;
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } dtx_t;

    logic        clk, rst;
    logic        ibus_req, ibus_ack, dbus_req, dbus_we, dbus_ack;
    logic [31:0] ibus_addr, ibus_rdata, dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        retire, halted, reg_write;
    logic [1:0]  trap_cause;
    logic [31:0] pc, instr, reg_wdata;
    logic [4:0]  reg_waddr;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    ret_t ret_q[$];
    dtx_t dtx_q[$];
    logic [31:0] imem [0:255];
    int  i_wait = 0;
    bit  i_mute = 0;
    bit  d_mute = 0;

    rv32i_multicycle_core #(
        .RESET_VECTOR(32'h0000_0100), .TIMEOUT_CYCLES(16), .TIMEOUT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .retire(retire), .halted(halted), .trap_cause(trap_cause), .pc(pc), .instr(instr),
        .reg_write(reg_write), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // sel: 0 retire, 1 halted, 2 ibus_req, 3 dbus_req
    task automatic wait_sig(input int sel, input int maxc, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if ((sel == 0 && retire) || (sel == 1 && halted) ||
                (sel == 2 && ibus_req) || (sel == 3 && dbus_req)) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s actual=not_seen expected=seen", name);
        end
    endtask

    task automatic push_ret(input logic [31:0] p, input logic we, input logic [4:0] rd, input logic [31:0] d);
        ret_t r;
        r.pc = p; r.we = we; r.rd = rd; r.data = d;
        ret_q.push_back(r);
    endtask

    task automatic push_dtx(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
        dtx_t t;
        t.addr = a; t.be = be; t.we = we; t.wdata = wd;
        dtx_q.push_back(t);
    endtask

    // Instruction memory responder with programmable wait states.
    initial begin
        int iw;
        iw = 0;
        ibus_ack = 1'b0;
        ibus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (ibus_req && !i_mute) begin
                if (iw >= i_wait) begin
                    ibus_ack = 1'b1;
                    ibus_rdata = imem[ibus_addr[9:2]];
                    iw = 0;
                end else begin
                    ibus_ack = 1'b0;
                    iw++;
                end
            end else begin
                ibus_ack = 1'b0;
                iw = 0;
            end
        end
    end

    // Data memory responder: zero-wait, fixed load word.
    initial begin
        dbus_ack = 1'b0;
        dbus_rdata = 32'h8000_0000;
        forever begin
            @(negedge clk);
            dbus_ack = dbus_req && !d_mute;
        end
    end

    // Monitor: compare each commit and each new data request against the queues.
    initial begin
        logic dreq_prev;
        ret_t r;
        dtx_t t;
        dreq_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && retire) begin
                if (ret_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL retire_unexpected actual=pc_%h expected=no_retire", pc);
                end else begin
                    r = ret_q.pop_front();
                    chk("retire_pc", pc, r.pc);
                    chk("retire_reg_write", {31'd0, reg_write}, {31'd0, r.we});
                    if (r.we) begin
                        chk("retire_waddr", {27'd0, reg_waddr}, {27'd0, r.rd});
                        chk("retire_wdata", reg_wdata, r.data);
                    end
                end
            end
            if (rst && dbus_req && !dreq_prev) begin
                if (dtx_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL dbus_unexpected actual=addr_%h expected=no_request", dbus_addr);
                end else begin
                    t = dtx_q.pop_front();
                    chk("dbus_addr", dbus_addr, t.addr);
                    chk("dbus_be", {28'd0, dbus_be}, {28'd0, t.be});
                    chk("dbus_we", {31'd0, dbus_we}, {31'd0, t.we});
                    if (t.we) chk("dbus_wdata", dbus_wdata, t.wdata);
                end
            end
            dreq_prev = dbus_req;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, nreq;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;

        // Program A: arithmetic, byte store/loads, taken branch, x0 write, misaligned LW.
        imem[64] = 32'h0050_0093;  // 100 ADDI x1,x0,5
        imem[65] = 32'h1234_5137;  // 104 LUI  x2,0x12345
        imem[66] = 32'h6781_0113;  // 108 ADDI x2,x2,0x678
        imem[67] = 32'h0020_01A3;  // 10C SB   x2,3(x0)
        imem[68] = 32'h0030_0183;  // 110 LB   x3,3(x0)
        imem[69] = 32'h0030_4203;  // 114 LBU  x4,3(x0)
        imem[70] = 32'h0000_0463;  // 118 BEQ  x0,x0,+8
        imem[71] = 32'h0010_0293;  // 11C ADDI x5,x0,1 (skipped)
        imem[72] = 32'h0030_8333;  // 120 ADD  x6,x1,x3
        imem[73] = 32'h0010_0013;  // 124 ADDI x0,x0,1
        imem[74] = 32'h2020_2383;  // 128 LW   x7,0x202(x0)
        repeat (3) @(negedge clk);
        chk("reset_ibus_req", {31'd0, ibus_req}, 32'd0);
        chk("reset_dbus_req", {31'd0, dbus_req}, 32'd0);
        chk("reset_status", {28'd0, halted, retire, reg_write, 1'b0}, 32'd0);
        chk("reset_trap_cause", {30'd0, trap_cause}, 32'd0);
        chk("reset_pc", pc, 32'h0000_0100);
        chk("reset_instr", instr, 32'd0);

        push_ret(32'h100, 1'b1, 5'd1, 32'h0000_0005);
        push_ret(32'h104, 1'b1, 5'd2, 32'h1234_5000);
        push_ret(32'h108, 1'b1, 5'd2, 32'h1234_5678);
        push_ret(32'h10C, 1'b0, 5'd0, 32'd0);
        push_ret(32'h110, 1'b1, 5'd3, 32'hFFFF_FF80);
        push_ret(32'h114, 1'b1, 5'd4, 32'h0000_0080);
        push_ret(32'h118, 1'b0, 5'd0, 32'd0);
        push_ret(32'h120, 1'b1, 5'd6, 32'hFFFF_FF85);
        push_ret(32'h124, 1'b0, 5'd0, 32'd0);
        push_dtx(32'h0, 4'b1000, 1'b1, 32'h7878_7878);
        push_dtx(32'h0, 4'b1000, 1'b0, 32'd0);
        push_dtx(32'h0, 4'b1000, 1'b0, 32'd0);

        rst = 1'b1;
        @(negedge clk);
        chk("first_fetch_req", {31'd0, ibus_req}, 32'd1);
        chk("first_fetch_addr", ibus_addr, 32'h0000_0100);
        chk("first_fetch_halted", {31'd0, halted}, 32'd0);
        c0 = cyc;
        wait_sig(0, 20, "addi_retire");
        chk("addi_latency", 32'(cyc - c0 + 1), 32'd4);
        @(negedge clk);
        chk("second_fetch_addr", ibus_addr, 32'h0000_0104);
        wait_sig(1, 300, "lw_misaligned_halt");
        chk("lw_trap_cause", {30'd0, trap_cause}, 32'd1);
        chk("trap_pc_frozen", pc, 32'h0000_0128);
        chk("trap_instr", instr, 32'h2020_2383);
        repeat (3) @(negedge clk);
        chk("trap_no_req", {30'd0, ibus_req, dbus_req}, 32'd0);
        chk("progA_ret_q_empty", 32'(ret_q.size()), 32'd0);
        chk("progA_dtx_q_empty", 32'(dtx_q.size()), 32'd0);

        // Program B: three fetch wait states, then a fetch that never completes.
        rst = 1'b0;
        imem[64] = 32'h0070_0093;  // ADDI x1,x0,7
        i_wait = 3;
        push_ret(32'h100, 1'b1, 5'd1, 32'h0000_0007);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        c0 = cyc;
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            if (ibus_req && ibus_addr == 32'h100) nreq++;
            else break;
            @(negedge clk);
        end
        chk("wait_fetch_req_cycles", 32'(nreq), 32'd4);
        wait_sig(0, 20, "wait_addi_retire");
        chk("wait_addi_latency", 32'(cyc - c0 + 1), 32'd7);
        i_mute = 1'b1;
        nreq = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (halted) break;
            if (ibus_req) nreq++;
        end
        chk("timeout_req_cycles", 32'(nreq), 32'd16);
        chk("timeout_halted", {31'd0, halted}, 32'd1);
        chk("timeout_cause", {30'd0, trap_cause}, 32'd3);

        // Program C: reset during a stalled SW, then restart into an illegal word.
        rst = 1'b0;
        i_mute = 1'b0;
        i_wait = 0;
        d_mute = 1'b1;
        imem[64] = 32'h0000_2023;  // SW x0,0(x0)
        push_dtx(32'h0, 4'b1111, 1'b1, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_sig(3, 20, "sw_dbus_req");
        #2 rst = 1'b0;
        #1;
        chk("async_drop_dbus_req", {31'd0, dbus_req}, 32'd0);
        chk("async_no_retire", {31'd0, retire}, 32'd0);
        chk("async_pc_reset", pc, 32'h0000_0100);
        imem[64] = 32'h0000_0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("restart_fetch_addr", ibus_addr, 32'h0000_0100);
        chk("restart_fetch_req", {31'd0, ibus_req}, 32'd1);
        wait_sig(1, 20, "illegal_halt");
        chk("illegal_cause", {30'd0, trap_cause}, 32'd0);
        repeat (2) @(negedge clk);
        chk("final_ret_q_empty", 32'(ret_q.size()), 32'd0);
        chk("final_dtx_q_empty", 32'(dtx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
